mem_port_arbiter: RTL and testbench

- Shares the single-port simple_memory between the instruction-fetch requester and the load/store (data) requester of the RISC-V core.
- Arbitrates between the two requesters, registers the winning request and drives the memory port for exactly one cycle.
- Captures read data and returns it with a one-cycle ack pulse.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and widths for the fetch/data memory-port arbiter.
//   arb_state_e  - arbiter FSM states
//   arb_req_id_e - identity of the granted requester
//   arb_latch_t  - request fields captured at grant time
package mem_port_arbiter_pkg;

   localparam int unsigned ARB_STREAK_W = 4;
   localparam int unsigned ARB_DATA_W   = 32;
   localparam int unsigned ARB_ADDR_W   = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_e;
   typedef enum logic {REQ_FETCH, REQ_DATA} arb_req_id_e;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0] addr;
      logic [ARB_DATA_W-1:0] wdata;
      logic                  we;
      logic                  err;
      arb_req_id_e           id;
   } arb_latch_t;

   // Word accesses only: any set low address bit is a misaligned data access.
   function automatic logic is_misaligned(input logic [ARB_ADDR_W-1:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and single-port memory bus of the arbiter.
//   slave  - arbiter view: takes requests and read data, drives acks and the memory port
//   master - environment view: drives requests and read data, observes acks and the memory port
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic                  if_req;
   logic [ARB_ADDR_W-1:0] if_addr;
   logic                  if_ack;
   logic [ARB_DATA_W-1:0] if_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ARB_ADDR_W-1:0] d_addr;
   logic [ARB_DATA_W-1:0] d_wdata;
   logic                  d_ack;
   logic [ARB_DATA_W-1:0] d_rdata;
   logic                  d_err;

   logic [ARB_ADDR_W-1:0] mem_address;
   logic [ARB_DATA_W-1:0] mem_write_data;
   logic                  mem_write_enable;
   logic [ARB_DATA_W-1:0] mem_read_data;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      output if_ack, if_rdata, d_ack, d_rdata, d_err,
             mem_address, mem_write_data, mem_write_enable
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      input  if_ack, if_rdata, d_ack, d_rdata, d_err,
             mem_address, mem_write_data, mem_write_enable
   );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data requests.
//   if_req, d_req - pending requests
//   streak        - consecutive data wins taken against a pending fetch
//   grant_valid   - some request is pending
//   grant_id      - winner; data by default, fetch once the streak reaches STARVE_LIMIT
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                    if_req,
   input  logic                    d_req,
   input  logic [ARB_STREAK_W-1:0] streak,
   output logic                    grant_valid,
   output arb_req_id_e             grant_id
);

   always_comb begin
      grant_valid = if_req | d_req;
      grant_id    = REQ_DATA;
      if (if_req && (!d_req || streak == ARB_STREAK_W'(STARVE_LIMIT))) begin
         grant_id = REQ_FETCH;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store.
//   clk, rst_n - clock and synchronous active-low reset
//   bus        - fetch port (if_*), data port (d_*) and memory port (mem_*)
// One access per three cycles: grant in IDLE, memory access in ACCESS, ack pulse in RESP.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   arb_state_e              state;
   logic [ARB_STREAK_W-1:0] streak;
   arb_latch_t              lat;
   logic                    if_ack_q;
   logic                    d_ack_q;
   logic                    d_err_q;
   logic [ARB_DATA_W-1:0]   if_rdata_q;
   logic [ARB_DATA_W-1:0]   d_rdata_q;

   logic                    grant_valid;
   arb_req_id_e             grant_id;
   logic                    d_mis;

   mem_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .if_req      (bus.if_req),
      .d_req       (bus.d_req),
      .streak      (streak),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign d_mis = is_misaligned(bus.d_addr);

   // Arbiter FSM, request latches, starvation streak and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         streak     <= '0;
         lat        <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         d_err_q    <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         unique case (state)
            ARB_IDLE: begin
               if (grant_valid) begin
                  lat.id <= grant_id;
                  if (grant_id == REQ_FETCH) begin
                     lat.addr <= bus.if_addr;
                     lat.we   <= 1'b0;
                     lat.err  <= 1'b0;
                  end else begin
                     lat.addr  <= bus.d_addr;
                     lat.wdata <= bus.d_wdata;
                     lat.we    <= bus.d_we & ~d_mis;
                     lat.err   <= d_mis;
                  end
                  // Streak only grows while a fetch is actually being passed over.
                  if (grant_id == REQ_FETCH || !bus.if_req) begin
                     streak <= '0;
                  end else if (streak != ARB_STREAK_W'(STARVE_LIMIT)) begin
                     streak <= streak + ARB_STREAK_W'(1);
                  end
                  state <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (lat.id == REQ_FETCH) begin
                  if_ack_q   <= 1'b1;
                  if_rdata_q <= bus.mem_read_data;
               end else begin
                  d_ack_q   <= 1'b1;
                  d_err_q   <= lat.err;
                  // Stores and misaligned accesses return zero data.
                  d_rdata_q <= (lat.we || lat.err) ? '0 : bus.mem_read_data;
               end
               state <= ARB_RESP;
            end
            ARB_RESP: begin
               state <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // Address and data hold their latched values; only the write strobe is cycle-qualified.
   assign bus.mem_address      = lat.addr;
   assign bus.mem_write_data   = lat.wdata;
   assign bus.mem_write_enable = (state == ARB_ACCESS) && lat.we && !lat.err && rst_n;

   assign bus.if_ack   = if_ack_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_ack    = d_ack_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.d_err    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model of arbitration order, latency and memory contents.
module tb_mem_port_arbiter;

   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write on posedge, plus preload ports for the bench.
   logic [31:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic        pl_fill = 1'b0;
   logic [7:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   logic [31:0] pl_seed = '0;

   function automatic logic [31:0] fill_word(input logic [31:0] seed, input int i);
      return seed ^ (32'(i) * 32'h9E37_79B1);
   endfunction

   assign bus.mem_read_data = mem[bus.mem_address[9:2]];

   always @(posedge clk) begin
      if (bus.mem_write_enable) mem[bus.mem_address[9:2]] <= bus.mem_write_data;
      else if (pl_fill) for (int i = 0; i < 256; i++) mem[i] <= fill_word(pl_seed, i);
      else if (pl_en) mem[pl_idx] <= pl_val;
   end

   task automatic preload(input int idx, input logic [31:0] val);
      pl_idx = 8'(idx); pl_val = val; pl_en = 1'b1;
      @(posedge clk); #1 pl_en = 1'b0;
   endtask

   task automatic clear_inputs();
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL reset_if_ack: got %b expected 0", bus.if_ack); end
      checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL reset_d_ack: got %b expected 0", bus.d_ack); end
      checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 0", bus.if_rdata); end
      checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h expected 0", bus.d_rdata); end
      checks++; if (bus.d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err: got %b expected 0", bus.d_err); end
      checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0", bus.mem_address); end
      checks++; if (bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_write_data: got %h expected 0", bus.mem_write_data); end
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_write_enable); end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_fetch();
      preload(0, 32'hDEAD_BEEF);
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.mem_address !== 32'h0) begin errors++; $display("FAIL fetch_mem_address: got %h expected 0", bus.mem_address); end
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b expected 0", bus.mem_write_enable); end
      @(negedge clk);
      checks++; if (bus.if_ack !== 1'b1) begin errors++; $display("FAIL fetch_if_ack: got %b expected 1", bus.if_ack); end
      checks++; if (bus.if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_if_rdata: got %h expected deadbeef", bus.if_rdata); end
      checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL fetch_d_ack: got %b expected 0", bus.d_ack); end
      @(posedge clk); #1 bus.if_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse: got %b expected 0", bus.if_ack); end
   endtask

   task automatic test_store_load();
      int we_cnt = 0;
      preload(30, 32'hFFFF_FFFF);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h78; bus.d_wdata = 32'h0000_CAFE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.mem_write_enable === 1'b1) we_cnt++;
      end
      checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL store_d_ack: got %b expected 1", bus.d_ack); end
      checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL store_d_rdata: got %h expected 0", bus.d_rdata); end
      checks++; if (we_cnt != 1) begin errors++; $display("FAIL store_we_cycles: got %0d expected 1", we_cnt); end
      @(posedge clk); #1 bus.d_we = 1'b0; bus.d_wdata = 32'h0;
      repeat (3) @(negedge clk);
      checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL load_d_ack: got %b expected 1", bus.d_ack); end
      checks++; if (bus.d_rdata !== 32'h0000_CAFE) begin errors++; $display("FAIL load_d_rdata: got %h expected 0000cafe", bus.d_rdata); end
      @(posedge clk); #1 bus.d_req = 1'b0;
   endtask

   task automatic test_misaligned();
      int we_cnt = 0;
      preload(20, 32'h0000_0005);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h52; bus.d_wdata = 32'h0BAD_0BAD;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.mem_write_enable !== 1'b0) we_cnt++;
      end
      checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL mis_d_ack: got %b expected 1", bus.d_ack); end
      checks++; if (bus.d_err !== 1'b1) begin errors++; $display("FAIL mis_d_err: got %b expected 1", bus.d_err); end
      checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL mis_d_rdata: got %h expected 0", bus.d_rdata); end
      checks++; if (we_cnt != 0) begin errors++; $display("FAIL mis_we_cycles: got %0d expected 0", we_cnt); end
      @(posedge clk); #1 bus.d_req = 1'b0; bus.d_we = 1'b0;
      checks++; if (mem[20] !== 32'h0000_0005) begin errors++; $display("FAIL mis_mem20: got %h expected 00000005", mem[20]); end
   endtask

   task automatic test_simultaneous();
      int d_t = -1;
      int f_t = -1;
      preload(0, 32'hDEAD_BEEF);
      preload(30, 32'h0000_CAFE);
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h78;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.d_ack === 1'b1 && d_t < 0) begin
            d_t = i;
            checks++; if (bus.d_rdata !== 32'h0000_CAFE) begin errors++; $display("FAIL sim_d_rdata: got %h expected 0000cafe", bus.d_rdata); end
         end
         if (bus.if_ack === 1'b1 && f_t < 0) begin
            f_t = i;
            checks++; if (bus.if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_if_rdata: got %h expected deadbeef", bus.if_rdata); end
         end
         @(posedge clk); #1;
         if (d_t >= 0) bus.d_req = 1'b0;
         if (f_t >= 0) bus.if_req = 1'b0;
      end
      checks++; if (d_t != 2) begin errors++; $display("FAIL sim_d_ack_cycle: got %0d expected 2", d_t); end
      checks++; if (f_t != 5) begin errors++; $display("FAIL sim_if_ack_cycle: got %0d expected 5", f_t); end
      clear_inputs();
   endtask

   task automatic test_input_change();
      preload(4, 32'h1111_1111);
      preload(8, 32'h2222_2222);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      @(posedge clk); #1 bus.d_addr = 32'h20; bus.d_wdata = 32'h0;
      @(negedge clk);
      checks++; if (bus.mem_address !== 32'h10) begin errors++; $display("FAIL chg_mem_address: got %h expected 10", bus.mem_address); end
      checks++; if (bus.mem_write_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL chg_mem_wdata: got %h expected a5a5a5a5", bus.mem_write_data); end
      @(negedge clk);
      checks++; if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL chg_d_ack: got %b expected 1", bus.d_ack); end
      @(posedge clk); #1 clear_inputs();
      checks++; if (mem[4] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL chg_mem4: got %h expected a5a5a5a5", mem[4]); end
      checks++; if (mem[8] !== 32'h2222_2222) begin errors++; $display("FAIL chg_mem8: got %h expected 22222222", mem[8]); end
   endtask

   task automatic test_reset_mid_store();
      preload(0, 32'hDEAD_BEEF);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0; bus.d_wdata = 32'h1234_5678;
      @(negedge clk);
      @(negedge clk);
      checks++; if (bus.mem_write_enable !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b expected 1", bus.mem_write_enable); end
      rst_n = 1'b0; clear_inputs();
      #1;
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL rst_gated_we: got %b expected 0", bus.mem_write_enable); end
      @(negedge clk);
      checks++; if (bus.d_ack !== 1'b0) begin errors++; $display("FAIL rst_d_ack: got %b expected 0", bus.d_ack); end
      checks++; if (bus.if_ack !== 1'b0) begin errors++; $display("FAIL rst_if_ack: got %b expected 0", bus.if_ack); end
      checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata: got %h expected 0", bus.if_rdata); end
      checks++; if (bus.mem_write_data !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h expected 0", bus.mem_write_data); end
      checks++; if (mem[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rst_mem0: got %h expected deadbeef", mem[0]); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_starvation();
      int n_d = 0;
      int f_t = -1;
      do_reset();
      bus.if_req = 1'b1; bus.if_addr = 32'h4;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h78;
      for (int i = 0; i < 40 && f_t < 0; i++) begin
         @(negedge clk);
         if (bus.d_ack === 1'b1) n_d++;
         if (bus.if_ack === 1'b1) f_t = i;
         @(posedge clk); #1;
      end
      clear_inputs();
      checks++; if (f_t < 0) begin errors++; $display("FAIL starve_timeout: got no if_ack expected one within 40 cycles"); end
      checks++; if (n_d != int'(LIMIT)) begin errors++; $display("FAIL starve_d_count: got %0d expected %0d", n_d, LIMIT); end
      checks++; if (f_t != 2 + 3 * int'(LIMIT)) begin errors++; $display("FAIL starve_if_cycle: got %0d expected %0d", f_t, 2 + 3 * int'(LIMIT)); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   typedef struct {
      int          due;
      bit          is_d;
      logic [31:0] data;
      bit          err;
   } exp_t;

   task automatic test_random();
      logic [31:0] ref_mem [0:255];
      exp_t        q[$];
      exp_t        e;
      bit          f_pend = 0, d_pend = 0, d_we = 0;
      logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0;
      int          free_at = 0;
      int          streak = 0;
      bit          s_fa, s_da, exp_fa, exp_da;
      do_reset();
      pl_seed = $urandom; pl_fill = 1'b1;
      @(posedge clk); #1 pl_fill = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = fill_word(pl_seed, i);
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         // Model: a free port grants the preferred pending request, ack two cycles later.
         if (c >= free_at && (f_pend || d_pend)) begin
            if (d_pend && !(f_pend && streak == int'(LIMIT))) begin
               e.is_d = 1; e.err = (d_addr[1:0] != 2'b00);
               if (e.err) e.data = 32'h0;
               else if (d_we) begin ref_mem[d_addr[9:2]] = d_wdata; e.data = 32'h0; end
               else e.data = ref_mem[d_addr[9:2]];
               streak = f_pend ? ((streak < int'(LIMIT)) ? streak + 1 : streak) : 0;
            end else begin
               e.is_d = 0; e.err = 0; e.data = ref_mem[f_addr[9:2]];
               streak = 0;
            end
            e.due = c + 2; q.push_back(e); free_at = c + 3;
         end
         exp_fa = (q.size() > 0 && q[0].due == c && !q[0].is_d);
         exp_da = (q.size() > 0 && q[0].due == c && q[0].is_d);
         s_fa = bus.if_ack; s_da = bus.d_ack;
         checks++; if (bus.if_ack !== exp_fa) begin errors++; $display("FAIL rnd_if_ack c=%0d: got %b expected %b", c, bus.if_ack, exp_fa); end
         checks++; if (bus.d_ack !== exp_da) begin errors++; $display("FAIL rnd_d_ack c=%0d: got %b expected %b", c, bus.d_ack, exp_da); end
         if (exp_fa) begin
            checks++; if (bus.if_rdata !== q[0].data) begin errors++; $display("FAIL rnd_if_rdata c=%0d: got %h expected %h", c, bus.if_rdata, q[0].data); end
         end
         if (exp_da) begin
            checks++; if (bus.d_rdata !== q[0].data) begin errors++; $display("FAIL rnd_d_rdata c=%0d: got %h expected %h", c, bus.d_rdata, q[0].data); end
            checks++; if (bus.d_err !== q[0].err) begin errors++; $display("FAIL rnd_d_err c=%0d: got %b expected %b", c, bus.d_err, q[0].err); end
         end
         if (exp_fa || exp_da) void'(q.pop_front());
         @(posedge clk); #1;
         // Requesters: drop or replace on ack, otherwise occasionally start a new request.
         if (s_fa === 1'b1) f_pend = 0;
         if (s_da === 1'b1) d_pend = 0;
         if (c < 660) begin
            if (!f_pend && $urandom_range(2, 0) == 0) begin
               f_pend = 1; f_addr = {22'h0, 8'($urandom), 2'($urandom)};
            end
            if (!d_pend && $urandom_range(1, 0) == 0) begin
               d_pend = 1; d_we = 1'($urandom);
               d_addr = {22'h0, 8'($urandom), ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00};
               d_wdata = $urandom;
            end
         end
         bus.if_req = f_pend; bus.if_addr = f_addr;
         bus.d_req = d_pend; bus.d_we = d_we; bus.d_addr = d_addr; bus.d_wdata = d_wdata;
      end
      checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d outstanding expected 0", q.size()); end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_fetch();
      test_store_load();
      test_misaligned();
      test_simultaneous();
      test_input_change();
      test_reset_mid_store();
      test_starvation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
